pe_array_sched: RTL and testbench
=================================

PE_ARRAY_SCHED -- requirements
Module: pe_array_sched

Interface
REQ-001 The block SHALL have parameter NUM_PE, default 16: number of PEs on the load chain; IDs 0..NUM_PE-1.
REQ-002 The block SHALL have parameter ID_WIDTH, default 6: width of the PE ID field.
REQ-003 The block SHALL have parameter IN_DATA_WIDTH, default 8: width of weights and activations.
REQ-004 The block SHALL have parameter LEN_WIDTH, default 16: width of cfg_len.
REQ-005 The block SHALL have parameter DRAIN_CYC, default NUM_PE+4: cycles between the last pop and done.
REQ-006 The block SHALL have port clk, input, 1 bit: clock; all logic is on the rising edge.
REQ-007 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-008 The block SHALL have the control ports: start (in, 1), one-cycle job request; cfg_len (in, LEN_WIDTH), activation beats per weight bank, sampled at accepted start; busy (out, 1); done (out, 1), one-cycle pulse.
REQ-009 The block SHALL have the weight stream ports s_wgt_vld (in, 1), s_wgt_data (in, IN_DATA_WIDTH) and s_wgt_rdy (out, 1).
REQ-010 The block SHALL have the activation stream ports s_act_vld (in, 1), s_act_data (in, IN_DATA_WIDTH) and s_act_rdy (out, 1).
REQ-011 The block SHALL have the array-side ports o_load_vld (1), o_load_id (ID_WIDTH), o_load_data (IN_DATA_WIDTH), o_pop_vld (1), o_left_vld (1) and o_left_data (IN_DATA_WIDTH), all outputs.

Function
REQ-012 The FSM SHALL have states IDLE, LOAD, FLUSH, COMP0, POP0, COMP1, POP1, DRAIN and DONE.
REQ-013 IDLE: start=1 SHALL latch cfg_len and go to LOAD; start is ignored in every other state.
REQ-014 LOAD: s_wgt_rdy SHALL be 1; exactly 2*NUM_PE beats are accepted (vld&rdy), and beat k carries ID floor(k/2): bank0 first, then bank1 per PE.
REQ-015 Each accepted weight beat SHALL appear one cycle later as o_load_vld=1, with o_load_id = PE ID and o_load_data = s_wgt_data; o_load_vld is 0 on all other cycles.
REQ-016 A LOAD stall (s_wgt_vld=0) SHALL insert bubbles only; the beat counter holds.
REQ-017 After the last weight beat, the FSM SHALL enter FLUSH for exactly NUM_PE+2 cycles, then go to COMP0; if latched cfg_len==0 it goes to DONE instead, with no pops issued.
REQ-018 COMP0/COMP1: s_act_rdy SHALL be 1, and each state accepts exactly cfg_len beats.
REQ-019 Each accepted activation beat SHALL appear one cycle later as o_left_vld=1 and o_left_data=s_act_data; on bubble cycles o_left_vld=0 and o_left_data=0.
REQ-020 POP0 and POP1 SHALL each last one cycle and produce o_pop_vld=1 for exactly one cycle, registered, one cycle after the state, so PE bank index goes 0->1->0.
REQ-021 State order SHALL be COMP0 -> POP0 -> COMP1 -> POP1 -> DRAIN.
REQ-022 DRAIN SHALL last DRAIN_CYC cycles, then go to DONE.
REQ-023 DONE SHALL assert done=1 for one cycle and return to IDLE; a new start is accepted no earlier than the following cycle.
REQ-024 busy SHALL be 1 in every state except IDLE.
REQ-025 s_wgt_rdy SHALL be 0 outside LOAD, and s_act_rdy SHALL be 0 outside COMP0/COMP1.
REQ-026 Beat counters SHALL be LEN_WIDTH wide (LOAD counter width covers 2*NUM_PE), and cfg_len = 2^LEN_WIDTH-1 SHALL complete without wrap-around.
REQ-027 All outputs SHALL be registered, with no combinational path from inputs to outputs, except s_wgt_rdy and s_act_rdy, which are decoded from the state register only.

Reset
REQ-028 Synchronous rst=1 SHALL force IDLE, clear all counters, and drive busy, done, s_wgt_rdy, s_act_rdy, o_load_vld, o_pop_vld and o_left_vld to 0, and o_load_id, o_load_data and o_left_data to 0.
REQ-029 rst asserted mid-job in any state SHALL take effect on the next edge, with no further beats or pops emitted; the downstream array is reset by the same rst.

Verification
REQ-030 NUM_PE=4, cfg_len=3, streams always valid: o_load_id sequence 0,0,1,1,2,2,3,3 -> FLUSH 6 cycles -> 3 o_left_vld beats, o_pop_vld pulse, 3 beats, o_pop_vld pulse -> done exactly DRAIN_CYC+1 cycles after the second pop.
REQ-031 NUM_PE=4, weight valid toggling 1,0,1,0: 8 o_load_vld beats total, with IDs unchanged across bubbles and data matching input order.
REQ-032 cfg_len=0: LOAD and FLUSH only, zero o_left_vld, zero o_pop_vld, then done pulse.
REQ-033 start held high for 40 cycles during a job: exactly one job runs, and a second job starts only if start is still high in IDLE after DONE.
REQ-034 rst asserted in COMP1 after 1 of 3 beats: next cycle all outputs are 0, state is IDLE, and a subsequent start runs a full, correct job.
REQ-035 Activation valid deasserted for 5 cycles in COMP0: o_left_vld=0 and o_left_data=0 for those cycles, and the beat count still totals cfg_len.

Source files
------------

// File: rtl/pe_array_sched.sv
// Job scheduler for a PE array: streams two weight banks onto the load chain, then two
// activation passes separated by bank-swap pops, then drains before signalling done.
module pe_array_sched #(
  parameter int unsigned NUM_PE        = 16,
  parameter int unsigned ID_WIDTH      = 6,
  parameter int unsigned IN_DATA_WIDTH = 8,
  parameter int unsigned LEN_WIDTH     = 16,
  parameter int unsigned DRAIN_CYC     = NUM_PE + 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [LEN_WIDTH-1:0]     cfg_len,
  output logic                     busy,
  output logic                     done,
  input  logic                     s_wgt_vld,
  input  logic [IN_DATA_WIDTH-1:0] s_wgt_data,
  output logic                     s_wgt_rdy,
  input  logic                     s_act_vld,
  input  logic [IN_DATA_WIDTH-1:0] s_act_data,
  output logic                     s_act_rdy,
  output logic                     o_load_vld,
  output logic [ID_WIDTH-1:0]      o_load_id,
  output logic [IN_DATA_WIDTH-1:0] o_load_data,
  output logic                     o_pop_vld,
  output logic                     o_left_vld,
  output logic [IN_DATA_WIDTH-1:0] o_left_data
);

  // One shared counter serves load beats, flush, activation beats and drain.
  localparam int unsigned AuxWidth = $clog2(2 * NUM_PE + DRAIN_CYC + 4);
  localparam int unsigned CntWidth = (LEN_WIDTH > AuxWidth) ? LEN_WIDTH : AuxWidth;

  typedef enum logic [3:0] {
    StIdle, StLoad, StFlush, StComp0, StPop0, StComp1, StPop1, StDrain, StDone
  } state_e;

  state_e                state_q;
  logic [CntWidth-1:0]   cnt_q;
  logic [LEN_WIDTH-1:0]  len_q;

  assign s_wgt_rdy = (state_q == StLoad);
  assign s_act_rdy = (state_q == StComp0) || (state_q == StComp1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      len_q       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      o_load_vld  <= 1'b0;
      o_load_id   <= '0;
      o_load_data <= '0;
      o_pop_vld   <= 1'b0;
      o_left_vld  <= 1'b0;
      o_left_data <= '0;
    end else begin
      o_load_vld  <= 1'b0;
      o_load_id   <= '0;
      o_load_data <= '0;
      o_pop_vld   <= 1'b0;
      o_left_vld  <= 1'b0;
      o_left_data <= '0;
      done        <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            len_q   <= cfg_len;
            cnt_q   <= '0;
            busy    <= 1'b1;
            state_q <= StLoad;
          end
        end
        StLoad: begin
          if (s_wgt_vld) begin
            o_load_vld  <= 1'b1;
            o_load_id   <= ID_WIDTH'(cnt_q >> 1);
            o_load_data <= s_wgt_data;
            if (cnt_q == CntWidth'(2 * NUM_PE - 1)) begin
              cnt_q   <= '0;
              state_q <= StFlush;
            end else begin
              cnt_q <= cnt_q + CntWidth'(1);
            end
          end
        end
        StFlush: begin
          if (cnt_q == CntWidth'(NUM_PE + 1)) begin
            cnt_q   <= '0;
            state_q <= (len_q == '0) ? StDone : StComp0;
          end else begin
            cnt_q <= cnt_q + CntWidth'(1);
          end
        end
        StComp0, StComp1: begin
          if (s_act_vld) begin
            o_left_vld  <= 1'b1;
            o_left_data <= s_act_data;
            // len_q is non-zero here, so len_q-1 cannot underflow.
            if (cnt_q == CntWidth'(len_q - LEN_WIDTH'(1))) begin
              cnt_q   <= '0;
              state_q <= (state_q == StComp0) ? StPop0 : StPop1;
            end else begin
              cnt_q <= cnt_q + CntWidth'(1);
            end
          end
        end
        StPop0: begin
          o_pop_vld <= 1'b1;
          state_q   <= StComp1;
        end
        StPop1: begin
          o_pop_vld <= 1'b1;
          state_q   <= StDrain;
        end
        StDrain: begin
          if (cnt_q == CntWidth'(DRAIN_CYC - 1)) begin
            cnt_q   <= '0;
            state_q <= StDone;
          end else begin
            cnt_q <= cnt_q + CntWidth'(1);
          end
        end
        StDone: begin
          done    <= 1'b1;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pe_array_sched.sv
// Directed bench for pe_array_sched with NUM_PE=4, DRAIN_CYC=8 and a 4-bit cfg_len so the
// maximum length can be exercised; expected cycle numbers are worked out by hand per scenario.
module tb_pe_array_sched;
  localparam int unsigned NP = 4;
  localparam int unsigned IW = 6;
  localparam int unsigned DW = 8;
  localparam int unsigned LW = 4;
  localparam int unsigned DC = NP + 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [LW-1:0] cfg_len = '0;
  logic          busy, done;
  logic          s_wgt_vld = 1'b0;
  logic [DW-1:0] s_wgt_data = '0;
  logic          s_wgt_rdy;
  logic          s_act_vld = 1'b0;
  logic [DW-1:0] s_act_data = '0;
  logic          s_act_rdy;
  logic          o_load_vld;
  logic [IW-1:0] o_load_id;
  logic [DW-1:0] o_load_data;
  logic          o_pop_vld;
  logic          o_left_vld;
  logic [DW-1:0] o_left_data;

  pe_array_sched #(
    .NUM_PE(NP), .ID_WIDTH(IW), .IN_DATA_WIDTH(DW), .LEN_WIDTH(LW), .DRAIN_CYC(DC)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len), .busy(busy), .done(done),
    .s_wgt_vld(s_wgt_vld), .s_wgt_data(s_wgt_data), .s_wgt_rdy(s_wgt_rdy),
    .s_act_vld(s_act_vld), .s_act_data(s_act_data), .s_act_rdy(s_act_rdy),
    .o_load_vld(o_load_vld), .o_load_id(o_load_id), .o_load_data(o_load_data),
    .o_pop_vld(o_pop_vld), .o_left_vld(o_left_vld), .o_left_data(o_left_data)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Per-job observation log; cycle 0 is the IDLE cycle in which start is first driven.
  logic [IW-1:0] ld_id  [64];
  logic [DW-1:0] ld_dat [64];
  int            ld_cyc [64];
  logic [DW-1:0] lf_dat [64];
  int            lf_cyc [64];
  int            pop_cyc[8];
  int n_load, n_left, n_pop, done_cyc, busy_cnt, wrdy_cnt, ardy_cnt, bubble_bad;

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; s_wgt_vld = 1'b0; s_act_vld = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // wmode 1: weight valid 1,0,1,0 from cycle 1. amode 1: 5 idle cycles after first act beat.
  task automatic run_job(input logic [LW-1:0] len, input int wmode, input int amode,
                         input int hold, input int abort_cyc, input int max_cyc);
    int wk, ak, gap;
    logic wv, av;
    n_load = 0; n_left = 0; n_pop = 0; done_cyc = -1;
    busy_cnt = 0; wrdy_cnt = 0; ardy_cnt = 0; bubble_bad = 0;
    wk = 0; ak = 0; gap = 0;
    cfg_len = len;
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk);
      if (o_load_vld) begin
        ld_id[n_load] = o_load_id; ld_dat[n_load] = o_load_data; ld_cyc[n_load] = c;
        n_load++;
      end
      if (o_left_vld) begin
        lf_dat[n_left] = o_left_data; lf_cyc[n_left] = c; n_left++;
      end else if (o_left_data !== '0) begin
        bubble_bad++;
      end
      if (o_pop_vld) begin
        if (n_pop < 8) pop_cyc[n_pop] = c;
        n_pop++;
      end
      busy_cnt += int'(busy); wrdy_cnt += int'(s_wgt_rdy); ardy_cnt += int'(s_act_rdy);
      if (done) begin
        done_cyc = c;
        break;
      end
      if (c == abort_cyc) begin
        rst = 1'b1;
        break;
      end
      start = (c < hold);
      wv = (wmode == 0) ? 1'b1 : (c >= 1 && ((c - 1) % 2 == 0));
      av = (gap == 0);
      if (gap > 0) gap--;
      s_wgt_vld = wv; s_wgt_data = 8'(8'hA0 + wk);
      s_act_vld = av; s_act_data = 8'(8'h50 + ak);
      if (wv && s_wgt_rdy) wk++;
      if (av && s_act_rdy) begin
        ak++;
        if (amode == 1 && ak == 1) gap = 5;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; s_wgt_vld = 1'b1; s_act_vld = 1'b1; cfg_len = 4'd3;
    s_wgt_data = 8'hFF; s_act_data = 8'hFF;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_vec++;
      if ({busy, done, s_wgt_rdy, s_act_rdy, o_load_vld, o_pop_vld, o_left_vld} !== 7'b0 ||
          o_load_id !== '0 || o_load_data !== '0 || o_left_data !== '0) begin
        n_err++;
        $display("FAIL reset_outputs: got busy=%b done=%b rdy=%b%b vld=%b%b%b id=%h ld=%h lf=%h want all 0",
                 busy, done, s_wgt_rdy, s_act_rdy, o_load_vld, o_pop_vld, o_left_vld,
                 o_load_id, o_load_data, o_left_data);
      end
    end
    start = 1'b0; s_wgt_vld = 1'b0; s_act_vld = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_basic(input string tag);
    run_job(4'd3, 0, 0, 1, -1, 80);
    n_vec++; if (done_cyc !== 32) begin n_err++;
      $display("FAIL %s_done_cyc: got %0d want 32", tag, done_cyc); end
    n_vec++; if (n_load !== 8) begin n_err++;
      $display("FAIL %s_load_cnt: got %0d want 8", tag, n_load); end
    for (int i = 0; i < 8; i++) begin
      n_vec++;
      if (ld_id[i] !== IW'(i / 2) || ld_dat[i] !== 8'(8'hA0 + i) || ld_cyc[i] !== 2 + i) begin
        n_err++;
        $display("FAIL %s_load_beat%0d: got id=%0d data=%h cyc=%0d want id=%0d data=%h cyc=%0d",
                 tag, i, ld_id[i], ld_dat[i], ld_cyc[i], i / 2, 8'(8'hA0 + i), 2 + i);
      end
    end
    n_vec++; if (n_left !== 6 || lf_cyc[0] !== 16 || lf_cyc[3] !== 20) begin n_err++;
      $display("FAIL %s_left: got n=%0d c0=%0d c3=%0d want n=6 c0=16 c3=20",
               tag, n_left, lf_cyc[0], lf_cyc[3]); end
    for (int i = 0; i < 6; i++) begin
      n_vec++; if (lf_dat[i] !== 8'(8'h50 + i)) begin n_err++;
        $display("FAIL %s_left_data%0d: got %h want %h", tag, i, lf_dat[i], 8'(8'h50 + i)); end
    end
    n_vec++; if (n_pop !== 2 || pop_cyc[0] !== 19 || pop_cyc[1] !== 23) begin n_err++;
      $display("FAIL %s_pop: got n=%0d at %0d,%0d want n=2 at 19,23",
               tag, n_pop, pop_cyc[0], pop_cyc[1]); end
    n_vec++; if (busy_cnt !== 31) begin n_err++;
      $display("FAIL %s_busy_cycles: got %0d want 31", tag, busy_cnt); end
    n_vec++; if (wrdy_cnt !== 8 || ardy_cnt !== 6) begin n_err++;
      $display("FAIL %s_rdy_cycles: got wgt=%0d act=%0d want wgt=8 act=6",
               tag, wrdy_cnt, ardy_cnt); end
    n_vec++; if (bubble_bad !== 0) begin n_err++;
      $display("FAIL %s_bubble_data: got %0d nonzero bubbles want 0", tag, bubble_bad); end
  endtask

  task automatic test_wgt_toggle();
    do_reset();
    run_job(4'd3, 1, 0, 1, -1, 80);
    n_vec++; if (n_load !== 8 || done_cyc !== 39) begin n_err++;
      $display("FAIL toggle_load_done: got n=%0d done=%0d want n=8 done=39", n_load, done_cyc); end
    for (int i = 0; i < 8; i++) begin
      n_vec++;
      if (ld_id[i] !== IW'(i / 2) || ld_dat[i] !== 8'(8'hA0 + i) || ld_cyc[i] !== 2 + 2 * i)
      begin
        n_err++;
        $display("FAIL toggle_beat%0d: got id=%0d data=%h cyc=%0d want id=%0d data=%h cyc=%0d",
                 i, ld_id[i], ld_dat[i], ld_cyc[i], i / 2, 8'(8'hA0 + i), 2 + 2 * i);
      end
    end
    n_vec++; if (wrdy_cnt !== 15 || busy_cnt !== 38 || n_left !== 6) begin n_err++;
      $display("FAIL toggle_counts: got wrdy=%0d busy=%0d left=%0d want 15 38 6",
               wrdy_cnt, busy_cnt, n_left); end
  endtask

  task automatic test_len_zero();
    do_reset();
    run_job(4'd0, 0, 0, 1, -1, 80);
    n_vec++; if (done_cyc !== 16 || busy_cnt !== 15) begin n_err++;
      $display("FAIL zero_done: got done=%0d busy=%0d want done=16 busy=15", done_cyc, busy_cnt); end
    n_vec++; if (n_left !== 0 || n_pop !== 0 || ardy_cnt !== 0 || n_load !== 8) begin n_err++;
      $display("FAIL zero_activity: got left=%0d pop=%0d ardy=%0d load=%0d want 0 0 0 8",
               n_left, n_pop, ardy_cnt, n_load); end
  endtask

  task automatic test_act_gap();
    do_reset();
    run_job(4'd3, 0, 1, 1, -1, 80);
    n_vec++; if (done_cyc !== 37 || n_left !== 6 || ardy_cnt !== 11) begin n_err++;
      $display("FAIL gap_counts: got done=%0d left=%0d ardy=%0d want 37 6 11",
               done_cyc, n_left, ardy_cnt); end
    n_vec++;
    if (lf_cyc[0] !== 16 || lf_cyc[1] !== 22 || lf_cyc[2] !== 23 || lf_cyc[3] !== 25) begin
      n_err++;
      $display("FAIL gap_left_cycles: got %0d,%0d,%0d,%0d want 16,22,23,25",
               lf_cyc[0], lf_cyc[1], lf_cyc[2], lf_cyc[3]);
    end
    n_vec++; if (bubble_bad !== 0 || lf_dat[1] !== 8'h51 || lf_dat[5] !== 8'h55) begin n_err++;
      $display("FAIL gap_data: got bubbles=%0d d1=%h d5=%h want 0 51 55",
               bubble_bad, lf_dat[1], lf_dat[5]); end
    n_vec++; if (n_pop !== 2 || pop_cyc[0] !== 24 || pop_cyc[1] !== 28) begin n_err++;
      $display("FAIL gap_pop: got n=%0d at %0d,%0d want 2 at 24,28", n_pop, pop_cyc[0], pop_cyc[1]);
    end
  endtask

  task automatic test_max_len();
    do_reset();
    run_job(4'd15, 0, 0, 1, -1, 100);
    n_vec++; if (done_cyc !== 56 || n_left !== 30) begin n_err++;
      $display("FAIL maxlen_done: got done=%0d left=%0d want 56 30", done_cyc, n_left); end
    n_vec++; if (n_pop !== 2 || pop_cyc[0] !== 31 || pop_cyc[1] !== 47) begin n_err++;
      $display("FAIL maxlen_pop: got n=%0d at %0d,%0d want 2 at 31,47",
               n_pop, pop_cyc[0], pop_cyc[1]); end
    n_vec++; if (lf_dat[14] !== 8'h5E || lf_dat[29] !== 8'h6D || lf_cyc[15] !== 32) begin n_err++;
      $display("FAIL maxlen_data: got d14=%h d29=%h c15=%0d want 5e 6d 32",
               lf_dat[14], lf_dat[29], lf_cyc[15]); end
  endtask

  task automatic test_start_held();
    do_reset();
    run_job(4'd10, 0, 0, 40, -1, 80);
    n_vec++; if (done_cyc !== 46 || n_load !== 8 || n_left !== 20) begin n_err++;
      $display("FAIL held_job: got done=%0d load=%0d left=%0d want 46 8 20",
               done_cyc, n_load, n_left); end
    n_vec++; if (n_pop !== 2 || pop_cyc[0] !== 26 || pop_cyc[1] !== 37) begin n_err++;
      $display("FAIL held_pop: got n=%0d at %0d,%0d want 2 at 26,37",
               n_pop, pop_cyc[0], pop_cyc[1]); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_vec++; if (busy !== 1'b0 || o_load_vld !== 1'b0) begin n_err++;
        $display("FAIL held_no_restart%0d: got busy=%b load_vld=%b want 0 0", i, busy, o_load_vld);
      end
    end
    // Start still high when the job returns to IDLE: a second job must begin.
    do_reset();
    run_job(4'd3, 0, 0, 40, -1, 80);
    n_vec++; if (done_cyc !== 32) begin n_err++;
      $display("FAIL held_short_done: got %0d want 32", done_cyc); end
    @(negedge clk);
    n_vec++; if (busy !== 1'b1) begin n_err++;
      $display("FAIL held_restart: got busy=%b want 1", busy); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    run_job(4'd3, 0, 0, 1, 20, 80);
    n_vec++; if (n_left !== 4 || n_pop !== 1) begin n_err++;
      $display("FAIL midrst_before: got left=%0d pop=%0d want 4 1", n_left, n_pop); end
    @(negedge clk);
    n_vec++;
    if ({busy, done, s_wgt_rdy, s_act_rdy, o_load_vld, o_pop_vld, o_left_vld} !== 7'b0 ||
        o_load_id !== '0 || o_load_data !== '0 || o_left_data !== '0) begin
      n_err++;
      $display("FAIL midrst_outputs: got busy=%b done=%b rdy=%b%b vld=%b%b%b lf=%h want all 0",
               busy, done, s_wgt_rdy, s_act_rdy, o_load_vld, o_pop_vld, o_left_vld, o_left_data);
    end
    rst = 1'b0; start = 1'b0;
    test_basic("midrst_rerun");
  endtask

  initial begin
    test_reset();
    test_basic("basic");
    test_wgt_toggle();
    test_len_zero();
    test_act_gap();
    test_max_len();
    test_start_held();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
